// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle SLL/SRL/SRA/ROTR shifter that moves the operand
// by at most STEP bit positions per clock.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           request, accepted only while idle (busy == 0)
//   op              00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   data_in, shamt  operand and shift amount, sampled on an accepted start
//   busy            high while the operation is shifting or finishing
//   done            one-cycle pulse marking result valid
//   result          shifted value, held until the next accepted start
module shift_unit_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic [1:0]           op_q, op_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [SHAMT_W-1:0]   k_c;
    logic [2*WIDTH-1:0]   rot_c;
    logic [WIDTH-1:0]     shifted_c;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    // Per-cycle step: never overshoot the remaining amount.
    assign k_c = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;

    // Rotate via a doubled word so the low bits wrap into the top.
    assign rot_c = {result_q, result_q} >> k_c;

    // One partial shift of the working value by k_c.
    always_comb begin
        shifted_c = result_q;
        case (op_q)
            OP_SLL:  shifted_c = result_q << k_c;
            OP_SRL:  shifted_c = result_q >> k_c;
            OP_SRA:  shifted_c = $unsigned($signed(result_q) >>> k_c);
            OP_ROTR: shifted_c = rot_c[WIDTH-1:0];
            default: shifted_c = result_q;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            op_q     <= OP_SLL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (shamt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                // Last step when what is left fits in one step.
                if (rem_q <= STEP_AMT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; busy/done follow the next state.
    always_comb begin
        result_d = result_q;
        rem_d    = rem_q;
        op_d     = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_d = data_in;
                    rem_d    = shamt;
                    op_d     = op;
                end
            end
            S_SHIFT: begin
                result_d = shifted_c;
                rem_d    = rem_q - k_c;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// Bench for shift_unit_iter: a STEP=1 and a STEP=4 instance share stimulus;
// a per-instance reference model predicts busy/done/result every cycle.
module tb_shift_unit_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [1:0]  busy_v, done_v;
    logic [31:0] res0, res1;

    int chk_total = 0;
    int chk_pass  = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .busy(busy_v[0]), .done(done_v[0]), .result(res0));

    shift_unit_iter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_s4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .busy(busy_v[1]), .done(done_v[1]), .result(res1));

    function automatic int step_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int lat_of(int sh, int st);
        return (sh + st - 1) / st + 1;
    endfunction

    // Whole-amount shift from the operation definitions.
    function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] d, int n);
        logic signed [31:0] s;
        s = d;
        case (o)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return s >>> n;
            default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
    endfunction

    function automatic logic [31:0] res_of(int i);
        return (i == 0) ? res0 : res1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: age = clock edges since the accepting edge.
    logic        m_active [2] = '{1'b0, 1'b0};
    logic [1:0]  m_op     [2];
    logic [31:0] m_data   [2];
    int          m_shamt  [2] = '{0, 0};
    int          m_age    [2] = '{0, 0};
    logic        check_en = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_active[i] <= 1'b0;
                m_age[i]    <= 0;
            end else if (!(m_active[i] && m_age[i] <= lat_of(m_shamt[i], step_of(i)) - 1)
                         && start) begin
                m_active[i] <= 1'b1;
                m_op[i]     <= op;
                m_data[i]   <= data_in;
                m_shamt[i]  <= int'(shamt);
                m_age[i]    <= 0;
            end else if (m_active[i] && m_age[i] < 64) begin
                m_age[i] <= m_age[i] + 1;
            end
        end
        if (reset) check_en <= 1'b1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] eres;
                logic        ebusy, edone;
                int          n, l;
                eres = '0; ebusy = 1'b0; edone = 1'b0;
                if (m_active[i]) begin
                    l = lat_of(m_shamt[i], step_of(i));
                    n = m_age[i] * step_of(i);
                    if (n > m_shamt[i]) n = m_shamt[i];
                    eres  = ref_shift(m_op[i], m_data[i], n);
                    ebusy = (m_age[i] <= l - 1);
                    edone = (m_age[i] == l - 1);
                end
                chk($sformatf("step%0d busy", step_of(i)), 32'(busy_v[i]), 32'(ebusy));
                chk($sformatf("step%0d done", step_of(i)), 32'(done_v[i]), 32'(edone));
                chk($sformatf("step%0d result", step_of(i)), res_of(i), eres);
            end
        end
    end

    // Issue one op, optionally pulse start at given cycles, then check
    // latency, done-pulse count and final result against hand values.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] sh,
                          input logic [31:0] exp_res, input int lat1, input int lat4,
                          input int p1, input int p2);
        int cnt;
        int lat   [2];
        int ndone [2];
        logic [31:0] rdone [2];
        lat = '{0, 0}; ndone = '{0, 0}; rdone = '{32'h0, 32'h0};
        start = 1'b1; op = o; data_in = d; shamt = sh;
        @(posedge clk); #1;
        cnt = 1;
        start = 1'b0; op = ~o; data_in = ~d; shamt = ~sh;
        while (cnt < 80) begin
            for (int k = 0; k < 2; k++) begin
                if (done_v[k]) begin
                    ndone[k]++;
                    if (lat[k] == 0) begin
                        lat[k]   = cnt;
                        rdone[k] = res_of(k);
                    end
                end
            end
            if (lat[0] != 0 && lat[1] != 0 && cnt >= lat[0] + 2 && cnt >= lat[1] + 2) break;
            start = (cnt == p1 || cnt == p2);
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        chk("step1 latency", 32'(lat[0]), 32'(lat1));
        chk("step4 latency", 32'(lat[1]), 32'(lat4));
        chk("step1 done count", 32'(ndone[0]), 32'd1);
        chk("step4 done count", 32'(ndone[1]), 32'd1);
        chk("step1 result at done", rdone[0], exp_res);
        chk("step4 result at done", rdone[1], exp_res);
        chk("step1 result held", res0, exp_res);
        chk("step4 result held", res1, exp_res);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;

        // Pin the reference function itself.
        chk("model sll", ref_shift(2'b00, 32'hA5A5A5A5, 2), 32'h96969694);
        chk("model sra", ref_shift(2'b10, 32'h80000000, 31), 32'hFFFFFFFF);
        chk("model rotr", ref_shift(2'b11, 32'h000000F1, 6), 32'hC4000003);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset busy", 32'(busy_v), 32'd0);
        chk("reset done", 32'(done_v), 32'd0);
        chk("reset result s1", res0, 32'd0);
        chk("reset result s4", res1, 32'd0);

        run_op(2'b00, 32'hA5A5A5A5, 5'd2,  32'h96969694, 3,  2, 0, 0);
        run_op(2'b01, 32'h80000000, 5'd31, 32'h00000001, 32, 9, 0, 0);
        run_op(2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 32, 9, 0, 0);
        run_op(2'b11, 32'h00000001, 5'd1,  32'h80000000, 2,  2, 0, 0);
        run_op(2'b10, 32'h80000000, 5'd0,  32'h80000000, 1,  1, 0, 0);
        run_op(2'b11, 32'h12345678, 5'd0,  32'h12345678, 1,  1, 0, 0);
        run_op(2'b00, 32'h00000001, 5'd5,  32'h00000020, 6,  3, 0, 0);
        run_op(2'b11, 32'h000000F1, 5'd6,  32'hC4000003, 7,  3, 0, 0);
        // Start pulses mid-SHIFT and during the STEP=4 DONE cycle.
        run_op(2'b00, 32'h00000001, 5'd8,  32'h00000100, 9,  3, 2, 3);

        // Reset mid-SHIFT aborts both instances.
        start = 1'b1; op = 2'b01; data_in = 32'hFFFF0000; shamt = 5'd20;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort busy", 32'(busy_v), 32'd0);
        chk("abort done", 32'(done_v), 32'd0);
        chk("abort result s1", res0, 32'd0);
        chk("abort result s4", res1, 32'd0);

        run_op(2'b10, 32'hF0000000, 5'd4, 32'hFF000000, 5, 2, 0, 0);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
